// File: rtl/cascade_cache_ctrl_if.sv
// Loader and requester bus of the cascade classifier cache controller.
// slave: controller side; master: loader/evaluator side.
interface cascade_cache_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_SIZE  = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
);
    logic                          load_start;
    logic [ADDR_WIDTH:0]           load_words;
    logic                          wr_valid;
    logic [WORD_SIZE-1:0]          wr_data;
    logic                          wr_ready;
    logic                          load_done;
    logic                          cache_ready;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic                          rsp_valid;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [WORD_SIZE-1:0]          rsp_data;

    modport slave (
        input  load_start, load_words, wr_valid, wr_data, req, req_addr,
        output wr_ready, load_done, cache_ready, gnt, rsp_valid, rsp_id,
               rsp_data
    );

    modport master (
        output load_start, load_words, wr_valid, wr_data, req, req_addr,
        input  wr_ready, load_done, cache_ready, gnt, rsp_valid, rsp_id,
               rsp_data
    );
endinterface

// File: rtl/cascade_cache_ctrl.sv
// Cascade cache controller: loads a cascade image into a simple dual-port
// RAM, then shares its read port among NUM_REQ requesters round-robin.
// Ports: clk, rst_n (async low), bus (loader + requester bus, slave side),
//   ram_waddr/ram_wdata/ram_we (write port), ram_raddr/ram_q (read port).
// Optional: CASCADE_CACHE_CHECKSUM_EN adds load_checksum (sum of loaded
//   words modulo 2^WORD_SIZE).
module cascade_cache_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_SIZE  = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cascade_cache_ctrl_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [WORD_SIZE-1:0]  ram_wdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [WORD_SIZE-1:0]  ram_q
`ifdef CASCADE_CACHE_CHECKSUM_EN
    ,
    output logic [WORD_SIZE-1:0]  load_checksum
`endif
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         words_q, words_d;
    logic                  done_q, done_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic                  start;
    logic                  found;
    logic [ID_WIDTH-1:0]   sel;
    int                    idx;
`ifdef CASCADE_CACHE_CHECKSUM_EN
    logic [WORD_SIZE-1:0]  sum_q, sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        words_d     = words_q;
        done_d      = 1'b0;
        ptr_d       = ptr_q;
        raddr_d     = raddr_q;
        rvalid_d    = 1'b0;
        rid_d       = rid_q;
        start       = 1'b0;
        found       = 1'b0;
        sel         = '0;
        idx         = 0;
        bus.wr_ready = 1'b0;
        bus.gnt     = '0;
        ram_we      = 1'b0;
        ram_raddr   = raddr_q;
`ifdef CASCADE_CACHE_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                start = bus.load_start;
            end
            ST_LOAD: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
`ifdef CASCADE_CACHE_CHECKSUM_EN
                    sum_d  = sum_q + bus.wr_data;
`endif
                    if (cnt_q == words_q - 1'b1) begin
                        state_d = ST_READY;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READY: begin
                start = bus.load_start;
                // Rotating search from the slot after the last grant.
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (int'(ptr_q) + k) % NUM_REQ;
                    if (!found && bus.req[idx]) begin
                        found = 1'b1;
                        sel   = ID_WIDTH'(idx);
                    end
                end
                if (found) begin
                    bus.gnt[sel] = 1'b1;
                    ram_raddr    = bus.req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    raddr_d      = ram_raddr;
                    rvalid_d     = 1'b1;
                    rid_d        = sel;
                    if (int'(sel) == NUM_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = sel + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            // A zero word count means a full RAM image.
            words_d = (bus.load_words == '0) ? (CW'(1) << ADDR_WIDTH)
                                             : bus.load_words;
`ifdef CASCADE_CACHE_CHECKSUM_EN
            sum_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            words_q  <= '0;
            done_q   <= 1'b0;
            ptr_q    <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
`ifdef CASCADE_CACHE_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            words_q  <= words_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
`ifdef CASCADE_CACHE_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign ram_waddr       = cnt_q[ADDR_WIDTH-1:0];
    assign ram_wdata       = bus.wr_data;
    assign bus.load_done   = done_q;
    assign bus.cache_ready = (state_q == ST_READY);
    assign bus.rsp_valid   = rvalid_q;
    assign bus.rsp_id      = rid_q;
    assign bus.rsp_data    = ram_q;
`ifdef CASCADE_CACHE_CHECKSUM_EN
    assign load_checksum   = sum_q;
`endif
endmodule

// File: tb/tb_cascade_cache_ctrl.sv
// Self-checking bench for cascade_cache_ctrl with a behavioural RAM and a
// reference model of loads and round-robin reads.
module tb_cascade_cache_ctrl;
    localparam int AW = 10;
    localparam int WS = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_waddr;
    logic [WS-1:0] ram_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_raddr;
    logic [WS-1:0] ram_q;
`ifdef CASCADE_CACHE_CHECKSUM_EN
    logic [WS-1:0] load_checksum;
`endif

    cascade_cache_ctrl_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS),
                            .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

    cascade_cache_ctrl #(.ADDR_WIDTH(AW), .WORD_SIZE(WS),
                         .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_raddr (ram_raddr),
`ifdef CASCADE_CACHE_CHECKSUM_EN
        .load_checksum (load_checksum),
`endif
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WS-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_q <= mem[ram_raddr];
    end

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [WS-1:0] exp_mem [0:(1<<AW)-1];
    logic [WS-1:0] ldata [$];
    logic [AW-1:0] addr_v [NR];
    int            ptr;
    bit            pv;
    int            pid;
    logic [WS-1:0] pdata;
    logic [AW-1:0] last_raddr;
    bit            ready_m;
    logic [WS-1:0] exp_sum;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0;
        pv = 0;
        last_raddr = '0;
        ready_m = 0;
    endtask

    // One READY cycle: drive requests, check grant, read address and the
    // response belonging to the previous cycle's grant.
    task automatic arb_cycle(input logic [NR-1:0] r);
        int g;
        bus.req = r;
        for (int i = 0; i < NR; i++) bus.req_addr[i*AW +: AW] = addr_v[i];
        #3;
        g = pick(r);
        chk("gnt", 32'(bus.gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("ram_raddr", 32'(ram_raddr),
            (g < 0) ? 32'(last_raddr) : 32'(addr_v[g]));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(pv));
        if (pv) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(pid));
            chk("rsp_data", 32'(bus.rsp_data), 32'(pdata));
        end
        if (g >= 0) begin
            ptr = (g + 1) % NR;
            last_raddr = addr_v[g];
            pv = 1;
            pid = g;
            pdata = exp_mem[addr_v[g]];
        end else begin
            pv = 0;
        end
        tick();
    endtask

    task automatic do_load(input int n, input bit gapped,
                           input logic [NR-1:0] start_req,
                           input logic [NR-1:0] during_req,
                           input int abort_after);
        int  idx;
        int  cyc;
        int  nw;
        bit  wv;
        bit  first;
        bus.load_start = 1'b1;
        bus.load_words = (AW+1)'(n);
        if (ready_m) arb_cycle(start_req);
        else tick();
        bus.load_start = 1'b0;
        ready_m = 0;
        bus.req = during_req;
        idx = 0;
        cyc = 0;
        nw = 0;
        first = 1;
        exp_sum = '0;
        while (idx < n && cyc < 4*n + 8) begin
            wv = gapped ? (cyc % 2 == 0) : 1'b1;
            bus.wr_valid = wv;
            bus.wr_data = ldata[idx];
            #3;
            chk("wr_ready", 32'(bus.wr_ready), 32'd1);
            chk("ram_we", 32'(ram_we), 32'(wv));
            if (ram_we) nw++;
            if (wv) begin
                chk("ram_waddr", 32'(ram_waddr), 32'(idx));
                chk("ram_wdata", 32'(ram_wdata), 32'(ldata[idx]));
            end
            chk("load_gnt", 32'(bus.gnt), 32'd0);
            chk("load_cache_ready", 32'(bus.cache_ready), 32'd0);
            chk("load_done_early", 32'(bus.load_done), 32'd0);
            chk("load_rsp_valid", 32'(bus.rsp_valid), first ? 32'(pv) : 32'd0);
            if (first && pv) begin
                chk("load_rsp_id", 32'(bus.rsp_id), 32'(pid));
                chk("load_rsp_data", 32'(bus.rsp_data), 32'(pdata));
            end
            if (wv) begin
                exp_mem[idx] = ldata[idx];
                exp_sum = exp_sum + ldata[idx];
                idx++;
            end
            first = 0;
            pv = 0;
            cyc++;
            if (abort_after >= 0 && idx == abort_after && wv) begin
                tick();
                bus.wr_valid = 1'b0;
                rst_n = 1'b0;
                #3;
                chk("rst_cache_ready", 32'(bus.cache_ready), 32'd0);
                chk("rst_load_done", 32'(bus.load_done), 32'd0);
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
                chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
                chk("rst_ram_waddr", 32'(ram_waddr), 32'd0);
                chk("rst_ram_raddr", 32'(ram_raddr), 32'd0);
                tick();
                rst_n = 1'b1;
                model_reset();
                tick();
                chk("idle_wr_ready", 32'(bus.wr_ready), 32'd0);
                return;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        chk("load_words_taken", 32'(idx), 32'(n));
        chk("write_count", 32'(nw), 32'(n));
        chk("load_done", 32'(bus.load_done), 32'd1);
        chk("cache_ready", 32'(bus.cache_ready), 32'd1);
`ifdef CASCADE_CACHE_CHECKSUM_EN
        chk("load_checksum", 32'(load_checksum), 32'(exp_sum));
`endif
        ready_m = 1;
        arb_cycle(during_req);
        chk("load_done_pulse", 32'(bus.load_done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.load_start = 1'b0;
        bus.load_words = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.req = '0;
        bus.req_addr = '0;
        for (int i = 0; i < NR; i++) addr_v[i] = AW'(i);
        for (int i = 0; i < (1<<AW); i++) exp_mem[i] = '0;
        model_reset();
        #12;
        chk("reset_cache_ready", 32'(bus.cache_ready), 32'd0);
        chk("reset_load_done", 32'(bus.load_done), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_ram_waddr", 32'(ram_waddr), 32'd0);
        chk("reset_ram_raddr", 32'(ram_raddr), 32'd0);
        chk("reset_gnt", 32'(bus.gnt), 32'd0);
        rst_n = 1'b1;
        tick();

        ldata = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(4, 1'b0, 4'b0000, 4'b0000, -1);
        chk("checksum_aa", 32'(exp_sum), 32'h0000_00aa);

        for (int i = 0; i < 8; i++) arb_cycle(4'b1111);
        arb_cycle(4'b0100);
        arb_cycle(4'b0101);
        arb_cycle(4'b0101);
        arb_cycle(4'b0000);

        ldata.delete();
        for (int i = 0; i < 3; i++) ldata.push_back(WS'($urandom_range(0, 255)));
        addr_v[0] = AW'(0);
        do_load(3, 1'b1, 4'b0001, 4'b0000, -1);
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NR; i++) addr_v[i] = AW'($urandom_range(0, 2));
            arb_cycle(NR'($urandom_range(0, 15)));
        end

        ldata.delete();
        for (int i = 0; i < 5; i++) ldata.push_back(WS'($urandom_range(0, 255)));
        do_load(5, 1'b0, 4'b0000, 4'b0000, 2);

        ldata.delete();
        for (int i = 0; i < 5; i++) ldata.push_back(WS'($urandom_range(0, 255)));
        for (int i = 0; i < NR; i++) addr_v[i] = AW'(i);
        do_load(5, 1'b0, 4'b0000, 4'b1111, -1);
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < NR; i++) addr_v[i] = AW'($urandom_range(0, 4));
            arb_cycle(NR'($urandom_range(0, 15)));
        end
        arb_cycle(4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cascade_cache_ctrl.md
Name: cascade_cache_ctrl

Overview:
- Sequences the cascade classifier cache (simple dual-port RAM: registered read address, unregistered read data, one write port).
- Streams a cascade image from the loader into the RAM, then shares the RAM read port among NUM_REQ stage-evaluator requesters with round-robin arbitration.
- Sits between the cascade loader and the feature/stage evaluators.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- WORD_SIZE, 8, RAM word width in bits.
- NUM_REQ, 4, number of read requesters (2..8).
- ID_WIDTH, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: begin loading; sampled in IDLE or READY only.
- load_words  in  ADDR_WIDTH+1  number of words to load, sampled with load_start; range 1..2^ADDR_WIDTH.
- wr_valid  in  1  loader word valid.
- wr_data  in  WORD_SIZE  loader word.
- wr_ready  out  1  controller accepts the loader word.
- load_done  out  1  one-cycle pulse when the final word has been written.
- cache_ready  out  1  cache holds a complete cascade and reads are allowed.
- req  in  NUM_REQ  per-requester read request; held until granted.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, packed; slice i belongs to req[i].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- rsp_valid  out  1  read data valid.
- rsp_id  out  ID_WIDTH  requester the data belongs to.
- rsp_data  out  WORD_SIZE  read data.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  WORD_SIZE  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_q  in  WORD_SIZE  RAM read data; valid the cycle after ram_raddr is sampled.

Behaviour:
- Reset values:
  - State IDLE; cache_ready, load_done, rsp_valid and wr_ready are 0.
  - rsp_id, ram_waddr, ram_raddr and the write counter are 0.
  - Round-robin pointer is 0, so requester 0 has highest priority first.
- FSM:
  - IDLE: load_start captures load_words and clears the write counter, then goes to LOAD.
  - LOAD: wr_ready=1. Each cycle with wr_valid && wr_ready:
    - ram_we=1, ram_waddr=counter, ram_wdata=wr_data;
    - counter increments.
    - When the accepted word is word load_words-1: load_done pulses in the next cycle and state goes to READY.
  - READY: cache_ready=1; arbitration enabled. load_start drops cache_ready in the next cycle and reloads via LOAD.
- ram_we is combinational from wr_valid && wr_ready; there is no write buffering.
- load_start in LOAD is ignored. load_words=0 is illegal; the controller treats it as 2^ADDR_WIDTH.
- Arbitration (READY only):
  - Search starts at requester (last_granted+1) mod NUM_REQ. The first requester with req high gets gnt.
  - ram_raddr is driven with that requester's address slice; last_granted is updated.
  - Exactly one grant per cycle, and back-to-back grants are allowed.
  - With no requests: gnt=0, pointer unchanged, ram_raddr holds its last value.
- Read latency: grant in cycle t gives rsp_valid=1, rsp_id=granted index and rsp_data=ram_q in cycle t+1. rsp_data passes ram_q through; rsp_id and rsp_valid are registered.
- Outside READY: gnt=0 and rsp_valid is 0 from the cycle after leaving READY.
- A grant issued in the last READY cycle still returns its rsp_valid one cycle later.
- Reset mid-load: the load is abandoned, cache_ready=0, and a new load_start is required. RAM contents are don't-care.

Optional Feature:
- Macro: CASCADE_CACHE_CHECKSUM_EN.
- When defined:
  - Adds output load_checksum, WORD_SIZE bits, the modulo-2^WORD_SIZE sum of all words accepted in the current load.
  - Cleared on load_start; valid when load_done pulses; held until the next load_start; reset value 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44 with wr_valid continuous -> ram_we high 4 cycles, waddr 0..3, load_done pulses once the cycle after word 3, cache_ready=1 from then. With CASCADE_CACHE_CHECKSUM_EN: load_checksum=0xAA.
- Load 3 words with wr_valid gapped (1,0,1,0,1) -> exactly 3 writes at addresses 0,1,2; no write while wr_valid=0.
- READY, req=4'b1111 held 8 cycles, addresses 0..3 -> gnt sequence 0,1,2,3,0,1,2,3. Each rsp_id matches the grant one cycle earlier, and rsp_data equals the loaded word.
- After granting requester 2, req=4'b0101 -> next grant is requester 0 (wrap-around), then 2.
- req asserted during LOAD -> gnt=0 and rsp_valid=0 until cache_ready=1; first grant goes to requester 0.
- rst_n low for one cycle mid-load after 2 of 5 words -> all outputs return to reset values. A following load of 5 words completes normally from address 0.
